// File: rtl/cache_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares one cacheline-wide backing-memory port between the
//               I-cache and the D-cache. Round-robin on ties, one transaction
//               in flight, registered memory strobes, one-cycle completion
//               pulses and saturating per-port grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // I-cache port (read only)
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // D-cache port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // Backing memory port
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    // Performance / debug
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt,
    output logic              spurious_resp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic              c_PORT_I    = 1'b0;
    localparam logic              c_PORT_D    = 1'b1;
    localparam logic [ADDR_W-1:0] c_LINE_MASK = {{(ADDR_W-5){1'b1}}, 5'b0_0000};
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic                r_last;       // port that won the previous grant
    logic                r_owner;      // port owning the transaction in flight
    logic                r_we;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_i_rdata;
    logic [LINE_W-1:0]   r_d_rdata;
    logic                r_i_resp;
    logic                r_d_resp;
    logic [CNT_W-1:0]    r_i_cnt;
    logic [CNT_W-1:0]    r_d_cnt;
    logic                r_spurious;

    logic                w_any_req;
    logic                w_grant_d;

    // D wins when it is the only requester, or on a tie when I won last time.
    assign w_any_req = i_req | d_req;
    assign w_grant_d = d_req & (~i_req | (r_last == c_PORT_I));

    // Arbitration FSM, transaction registers, responses and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last      <= c_PORT_I;
            r_owner     <= c_PORT_I;
            r_we        <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_resp    <= 1'b0;
            r_d_resp    <= 1'b0;
            r_i_cnt     <= '0;
            r_d_cnt     <= '0;
            r_spurious  <= 1'b0;
        end else begin
            // Completion pulses last a single cycle by default.
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;

            // A memory completion outside BUSY has no transaction to finish.
            if (mem_resp && (r_state != ST_BUSY)) begin
                r_spurious <= 1'b1;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ST_BUSY;
                        r_owner     <= w_grant_d;
                        r_last      <= w_grant_d;
                        r_we        <= w_grant_d & d_we;
                        r_mem_read  <= ~(w_grant_d & d_we);
                        r_mem_write <= w_grant_d & d_we;
                        r_addr      <= (w_grant_d ? d_addr : i_addr) & c_LINE_MASK;
                        r_wdata     <= w_grant_d ? d_wdata : '0;
                        if (w_grant_d) begin
                            if (r_d_cnt != c_CNT_MAX) begin
                                r_d_cnt <= r_d_cnt + c_CNT_ONE;
                            end
                        end else begin
                            if (r_i_cnt != c_CNT_MAX) begin
                                r_i_cnt <= r_i_cnt + c_CNT_ONE;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_resp) begin
                        r_state     <= ST_RESP;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        // Fills update the owner's data; write-backs leave it alone.
                        if (!r_we) begin
                            if (r_owner == c_PORT_D) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_i_rdata <= mem_rdata;
                            end
                        end
                        if (r_owner == c_PORT_D) begin
                            r_d_resp <= 1'b1;
                        end else begin
                            r_i_resp <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign i_rdata       = r_i_rdata;
    assign d_rdata       = r_d_rdata;
    assign i_resp        = r_i_resp;
    assign d_resp        = r_d_resp;
    assign i_grant_cnt   = r_i_cnt;
    assign d_grant_cnt   = r_d_cnt;
    assign spurious_resp = r_spurious;

endmodule
`default_nettype wire
